// File: rtl/pse_area_calc.sv
// pse_area_calc
//   Streaming shoelace-area consumer for the clockwise point sorter.
//   Accepts one polygon per frame as a valid/X/Y point stream. It accumulates
//   the shoelace sum, closes the polygon back to its first point, and
//   reports twice the enclosed area together with the winding sign.
//
// Parameters
//   CW : coordinate width (unsigned coordinates)
//   AW : signed accumulator width, at least 2*CW+4
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset, clears all state
//   valid      : point strobe, one point per cycle while high
//   Xin, Yin   : point coordinates, sampled when valid=1
//   point_num  : points in the frame, latched on the frame's first valid
//   area_valid : one-cycle strobe, area2/orient just updated
//   area2      : |shoelace sum| (twice the polygon area)
//   orient     : 1 when the signed sum was negative (clockwise)
module pse_area_calc #(
    parameter int CW = 10,
    parameter int AW = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [CW-1:0]   Xin,
    input  logic [CW-1:0]   Yin,
    input  logic [2:0]      point_num,
    output logic            area_valid,
    output logic [2*CW:0]   area2,
    output logic            orient
);

    typedef enum logic [1:0] {IDLE, ACC, CLOSE} state_t;

    state_t state, state_next;

    logic [CW-1:0]        fx, fy, px, py;
    logic [2:0]           n, cnt;
    logic signed [AW-1:0] acc;

    logic                 start_ok, last_pt;
    logic                 load_first, acc_step, do_close;
    logic signed [AW-1:0] step_term, close_sum;

    // term(a,b) = ax*by - bx*ay. Operands are zero-extended so the unsigned
    // products stay exact. The signed difference is then sign-extended to AW.
    function automatic logic signed [AW-1:0] term(
        input logic [CW-1:0] ax,
        input logic [CW-1:0] ay,
        input logic [CW-1:0] bx,
        input logic [CW-1:0] by
    );
        logic [2*CW-1:0]   m1, m2;
        logic signed [2*CW:0] t;
        m1 = {{CW{1'b0}}, ax} * {{CW{1'b0}}, by};
        m2 = {{CW{1'b0}}, bx} * {{CW{1'b0}}, ay};
        t  = $signed({1'b0, m1}) - $signed({1'b0, m2});
        return {{(AW-2*CW-1){t[2*CW]}}, t};
    endfunction

    // Magnitude of the closed sum. It always fits in 2*CW+1 bits for convex
    // polygons inside the coordinate box, so only the low bits are kept.
    function automatic logic [2*CW:0] abs_trunc(input logic signed [AW-1:0] s);
        logic signed [AW-1:0] m;
        m = s[AW-1] ? -s : s;
        return m[2*CW:0];
    endfunction

    assign start_ok  = valid && (point_num >= 3'd3);
    assign last_pt   = ((cnt + 3'd1) == n);
    assign step_term = term(px, py, Xin, Yin);
    assign close_sum = acc + term(px, py, fx, fy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_ok) state_next = ACC;
            ACC:     if (valid && last_pt) state_next = CLOSE;
            // A point arriving during CLOSE opens the next frame at once.
            CLOSE:   state_next = start_ok ? ACC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_first = 1'b0;
        acc_step   = 1'b0;
        do_close   = 1'b0;
        unique case (state)
            IDLE:    load_first = start_ok;
            ACC:     acc_step   = valid;
            CLOSE: begin
                do_close   = 1'b1;
                load_first = start_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fx         <= '0;
            fy         <= '0;
            px         <= '0;
            py         <= '0;
            n          <= '0;
            cnt        <= '0;
            acc        <= '0;
            area_valid <= 1'b0;
            area2      <= '0;
            orient     <= 1'b0;
        end else begin
            area_valid <= do_close;
            if (do_close) begin
                area2  <= abs_trunc(close_sum);
                orient <= close_sum[AW-1];
            end
            if (load_first) begin
                fx  <= Xin;
                fy  <= Yin;
                px  <= Xin;
                py  <= Yin;
                n   <= point_num;
                cnt <= 3'd1;
                acc <= '0;
            end else if (acc_step) begin
                acc <= acc + step_term;
                px  <= Xin;
                py  <= Yin;
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_pse_area_calc.sv
module tb_pse_area_calc;

    localparam int CW = 10;
    localparam int AW = 24;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            valid = 1'b0;
    logic [CW-1:0]   Xin = '0;
    logic [CW-1:0]   Yin = '0;
    logic [2:0]      point_num = '0;
    logic            area_valid;
    logic [2*CW:0]   area2;
    logic            orient;

    pse_area_calc #(.CW(CW), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .Xin        (Xin),
        .Yin        (Yin),
        .point_num  (point_num),
        .area_valid (area_valid),
        .area2      (area2),
        .orient     (orient)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*CW:0] a;
        logic          o;
    } exp_t;

    exp_t sb[$];
    int   pulse_log[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pulse = 0;
    int   cyc = 0;

    int   tx[7];
    int   ty[7];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every area_valid pulse is matched against the oldest
    // expected result queued when its frame was driven.
    always @(negedge clk) begin
        if (area_valid === 1'b1) begin
            exp_t e;
            n_pulse = n_pulse + 1;
            pulse_log.push_back(cyc);
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_pulse: area_valid=1 area2=%0d orient=%0d, required no pulse", area2, orient);
            end else begin
                e = sb.pop_front();
                if (area2 !== e.a) begin
                    n_err = n_err + 1;
                    $display("FAIL area2: got %0d, required %0d", area2, e.a);
                end
                n_cmp = n_cmp + 1;
                if (orient !== e.o) begin
                    n_err = n_err + 1;
                    $display("FAIL orient: got %0d, required %0d", orient, e.o);
                end
            end
        end
    end

    // Reference shoelace sum over the closed polygon held in tx/ty.
    function automatic longint shoelace(input int np);
        longint s = 0;
        for (int i = 0; i < np; i++) begin
            int j = (i + 1) % np;
            s += longint'(tx[i]) * longint'(ty[j]) - longint'(tx[j]) * longint'(ty[i]);
        end
        return s;
    endfunction

    task automatic push_expected(input int np);
        exp_t   e;
        longint s;
        longint m;
        s = shoelace(np);
        m = (s < 0) ? -s : s;
        e.a = (2*CW+1)'(m);
        e.o = (s < 0);
        sb.push_back(e);
    endtask

    task automatic send_point(input int x, input int y, input int pn);
        @(negedge clk);
        valid     = 1'b1;
        Xin       = CW'(x);
        Yin       = CW'(y);
        point_num = 3'(pn);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    // Drives tx/ty[0..np-1]; leaves valid high after the last point.
    task automatic send_frame(input int np, input int pn, input int gapmax,
                              input bit toggle, input bit expect_result);
        if (expect_result) push_expected(np);
        for (int i = 0; i < np; i++) begin
            if (i > 0 && gapmax > 0) begin
                int g = $urandom_range(gapmax, 0);
                repeat (g) begin
                    @(negedge clk);
                    valid = 1'b0;
                    if (toggle) point_num = 3'($urandom_range(7, 0));
                end
            end
            send_point(tx[i], ty[i],
                       (i == 0 || !toggle) ? pn : int'($urandom_range(7, 0)));
        end
    endtask

    task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
        tx[0] = x0; ty[0] = y0;
        tx[1] = x1; ty[1] = y1;
        tx[2] = x2; ty[2] = y2;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp = n_cmp + 1;
        if (area_valid !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL reset_area_valid: got %0d, required 0", area_valid);
        end
        n_cmp = n_cmp + 1;
        if (area2 !== '0) begin
            n_err = n_err + 1;
            $display("FAIL reset_area2: got %0d, required 0", area2);
        end
        n_cmp = n_cmp + 1;
        if (orient !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL reset_orient: got %0d, required 0", orient);
        end
        reset = 1'b0;
        idle_cycles(2);
    endtask

    // Last point sampled at edge E: CLOSE in E..E+1, pulse visible after E+1.
    task automatic test_triangle_ccw;
        set_tri(0, 0, 10, 0, 0, 10);
        send_frame(3, 3, 0, 1'b0, 1'b1);
        @(negedge clk);
        valid = 1'b0;
        n_cmp = n_cmp + 1;
        if (area_valid !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL latency_close_cycle: area_valid=%0d, required 0", area_valid);
        end
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if (area_valid !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL latency_pulse: area_valid=%0d, required 1", area_valid);
        end
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if (area_valid !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL pulse_width: area_valid=%0d, required 0", area_valid);
        end
        n_cmp = n_cmp + 1;
        if (area2 !== 21'd100) begin
            n_err = n_err + 1;
            $display("FAIL area2_hold: got %0d, required 100", area2);
        end
        idle_cycles(2);
    endtask

    task automatic test_cw_and_square;
        int p0;
        p0 = n_pulse;
        set_tri(0, 0, 0, 10, 10, 0);
        send_frame(3, 3, 0, 1'b0, 1'b1);
        idle_cycles(3);
        tx[0] = 0;    ty[0] = 0;
        tx[1] = 0;    ty[1] = 1023;
        tx[2] = 1023; ty[2] = 1023;
        tx[3] = 1023; ty[3] = 0;
        send_frame(4, 4, 0, 1'b0, 1'b1);
        idle_cycles(4);
        n_cmp = n_cmp + 1;
        if (area2 !== 21'd2093058 || orient !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL square: area2=%0d orient=%0d, required 2093058/1", area2, orient);
        end
        n_cmp = n_cmp + 1;
        if (n_pulse - p0 !== 2) begin
            n_err = n_err + 1;
            $display("FAIL cw_square_pulses: got %0d, required 2", n_pulse - p0);
        end
    endtask

    task automatic test_gaps;
        int p0;
        p0 = n_pulse;
        set_tri(0, 0, 10, 0, 0, 10);
        send_frame(3, 3, 3, 1'b1, 1'b1);
        idle_cycles(5);
        n_cmp = n_cmp + 1;
        if (n_pulse - p0 !== 1) begin
            n_err = n_err + 1;
            $display("FAIL gaps_pulses: got %0d, required 1", n_pulse - p0);
        end
    endtask

    // Frame B's first point lands in frame A's CLOSE cycle; B's last point
    // follows two edges later, so the pulses are three edges apart.
    task automatic test_back_to_back;
        int p0;
        p0 = n_pulse;
        pulse_log.delete();
        set_tri(0, 0, 10, 0, 0, 10);
        send_frame(3, 3, 0, 1'b0, 1'b1);
        set_tri(5, 5, 5, 25, 45, 5);
        send_frame(3, 3, 0, 1'b0, 1'b1);
        idle_cycles(5);
        n_cmp = n_cmp + 1;
        if (n_pulse - p0 !== 2) begin
            n_err = n_err + 1;
            $display("FAIL b2b_pulses: got %0d, required 2", n_pulse - p0);
        end else begin
            n_cmp = n_cmp + 1;
            if (pulse_log[1] - pulse_log[0] !== 3) begin
                n_err = n_err + 1;
                $display("FAIL b2b_spacing: got %0d, required 3", pulse_log[1] - pulse_log[0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int p0;
        p0 = n_pulse;
        send_point(0, 0, 4);
        send_point(0, 1023, 4);
        @(negedge clk);
        valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp = n_cmp + 1;
        if (area2 !== '0 || orient !== 1'b0 || area_valid !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL async_reset: area2=%0d orient=%0d area_valid=%0d, required 0/0/0",
                     area2, orient, area_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(3);
        n_cmp = n_cmp + 1;
        if (n_pulse - p0 !== 0) begin
            n_err = n_err + 1;
            $display("FAIL reset_no_pulse: got %0d pulses, required 0", n_pulse - p0);
        end
        set_tri(0, 0, 10, 0, 0, 10);
        send_frame(3, 3, 0, 1'b0, 1'b1);
        idle_cycles(4);
        n_cmp = n_cmp + 1;
        if (area2 !== 21'd100) begin
            n_err = n_err + 1;
            $display("FAIL after_reset_area2: got %0d, required 100", area2);
        end
    endtask

    task automatic test_short_frame;
        int p0;
        p0 = n_pulse;
        send_point(100, 100, 2);
        send_point(200, 300, 2);
        idle_cycles(4);
        n_cmp = n_cmp + 1;
        if (n_pulse - p0 !== 0) begin
            n_err = n_err + 1;
            $display("FAIL short_frame_pulse: got %0d pulses, required 0", n_pulse - p0);
        end
        set_tri(20, 10, 20, 50, 90, 30);
        send_frame(3, 3, 0, 1'b0, 1'b1);
        idle_cycles(4);
        n_cmp = n_cmp + 1;
        if (n_pulse - p0 !== 1) begin
            n_err = n_err + 1;
            $display("FAIL after_short_pulses: got %0d, required 1", n_pulse - p0);
        end
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 12; f++) begin
            int np = $urandom_range(7, 3);
            for (int i = 0; i < np; i++) begin
                tx[i] = $urandom_range(300, 0);
                ty[i] = $urandom_range(300, 0);
            end
            send_frame(np, np, 2, 1'b1, 1'b1);
            if ($urandom_range(1, 0) == 1) idle_cycles($urandom_range(3, 1));
        end
        idle_cycles(4);
    endtask

    task automatic test_drain;
        int waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL drain: %0d results still outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_triangle_ccw();
        test_cw_and_square();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        test_short_frame();
        test_random_frames();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
